// File: rtl/bank_pkg.sv
// Shared bank geometry for the ISU rob allocator, SRAM controller and return-path rob.
package bank_pkg;
    localparam int unsigned BANK_CH_NUM    = 4;
    localparam int unsigned BANK_ROB_DEPTH = 8;
    localparam int unsigned BANK_DATA_W    = 128;
    localparam int unsigned BANK_CH_W      = $clog2(BANK_CH_NUM);
    localparam int unsigned BANK_ROB_W     = $clog2(BANK_ROB_DEPTH);
endpackage

// File: rtl/bank_rtn_rob_if.sv
// Return-path bundle: tagged beats in from the SRAM controller, ordered beats out to the xbar.
interface bank_rtn_rob_if
    import bank_pkg::*;
#(
    parameter int unsigned CH_NUM    = BANK_CH_NUM,
    parameter int unsigned ROB_DEPTH = BANK_ROB_DEPTH,
    parameter int unsigned DATA_W    = BANK_DATA_W
);
    localparam int unsigned CH_W  = $clog2(CH_NUM);
    localparam int unsigned ROB_W = $clog2(ROB_DEPTH);

    logic              sc_xbar_valid;
    logic              sc_xbar_ready;
    logic [CH_W-1:0]   sc_xbar_channel_id;
    logic [ROB_W-1:0]  sc_xbar_rob_num;
    logic [DATA_W-1:0] sc_xbar_data;
    logic              xbar_rtn_valid;
    logic              xbar_rtn_ready;
    logic [CH_W-1:0]   xbar_rtn_channel_id;
    logic [ROB_W-1:0]  xbar_rtn_rob_num;
    logic [DATA_W-1:0] xbar_rtn_data;
    logic [CH_NUM-1:0] rob_empty;

    modport slave (
        input  sc_xbar_valid, sc_xbar_channel_id, sc_xbar_rob_num, sc_xbar_data, xbar_rtn_ready,
        output sc_xbar_ready, xbar_rtn_valid, xbar_rtn_channel_id, xbar_rtn_rob_num,
        output xbar_rtn_data, rob_empty
    );

    modport master (
        output sc_xbar_valid, sc_xbar_channel_id, sc_xbar_rob_num, sc_xbar_data, xbar_rtn_ready,
        input  sc_xbar_ready, xbar_rtn_valid, xbar_rtn_channel_id, xbar_rtn_rob_num,
        input  xbar_rtn_data, rob_empty
    );
endinterface

// File: rtl/bank_rr_arb.sv
// N-way round-robin arbiter: search starts one past the last granted requester.
module bank_rr_arb
    import bank_pkg::*;
#(
    parameter int unsigned N = BANK_CH_NUM
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req_i,
    input  logic         upd_i,
    output logic [N-1:0] gnt_o
);
    localparam int unsigned PTR_W = $clog2(N);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             found;
    int unsigned      idx;

    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = (i + ptr_q) % N;
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                if (upd_i) ptr_d = PTR_W'(idx);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) ptr_q <= PTR_W'(N - 1);
        else       ptr_q <= ptr_d;
    end
endmodule

// File: rtl/bank_rtn_rob.sv
// Per-channel return reorder buffer: releases beats in rob order per channel, RR across channels.
// Optional same-cycle head bypass for idle channels under BANK_RTN_ROB_BYPASS_EN.
module bank_rtn_rob
    import bank_pkg::*;
#(
    parameter int unsigned CH_NUM    = BANK_CH_NUM,
    parameter int unsigned ROB_DEPTH = BANK_ROB_DEPTH,
    parameter int unsigned DATA_W    = BANK_DATA_W
) (
    input logic         clk_i,
    input logic         rst_i,
    bank_rtn_rob_if.slave bus
);
    localparam int unsigned CH_W  = $clog2(CH_NUM);
    localparam int unsigned ROB_W = $clog2(ROB_DEPTH);

    logic [ROB_DEPTH-1:0] valid_q [CH_NUM];
    logic [ROB_DEPTH-1:0] valid_d [CH_NUM];
    logic [ROB_W-1:0]     head_q  [CH_NUM];
    logic [ROB_W-1:0]     head_d  [CH_NUM];
    logic [DATA_W-1:0]    mem_q   [CH_NUM][ROB_DEPTH];

    logic              out_valid_q, out_valid_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic [ROB_W-1:0]  out_rob_q, out_rob_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic [CH_W-1:0]   in_ch;
    logic [ROB_W-1:0]  in_rob;
    logic [CH_NUM-1:0] cand, req, gnt, rob_empty;
    logic [CH_W-1:0]   gnt_ch;
    logic              acc, load_en, bypass;

    assign in_ch  = bus.sc_xbar_channel_id;
    assign in_rob = bus.sc_xbar_rob_num;

    always_comb begin
        cand      = '0;
        rob_empty = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            cand[c]      = valid_q[c][head_q[c]];
            rob_empty[c] = ~|valid_q[c];
        end
    end

    assign bus.sc_xbar_ready = !rst_i && !valid_q[in_ch][in_rob];
    assign acc     = bus.sc_xbar_valid && bus.sc_xbar_ready;
    assign load_en = !out_valid_q || bus.xbar_rtn_ready;

`ifdef BANK_RTN_ROB_BYPASS_EN
    // Only when nothing else is waiting, so bypass never jumps ahead of stored beats.
    assign bypass = acc && load_en && ~|cand && rob_empty[in_ch] && (in_rob == head_q[in_ch]);
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        req = cand;
        if (bypass) req[in_ch] = 1'b1;
    end

    bank_rr_arb #(
        .N(CH_NUM)
    ) u_arb (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .req_i(req),
        .upd_i(load_en),
        .gnt_o(gnt)
    );

    always_comb begin
        gnt_ch = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            if (gnt[c]) gnt_ch = CH_W'(c);
        end
    end

    always_comb begin
        valid_d     = valid_q;
        head_d      = head_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        out_rob_d   = out_rob_q;
        out_data_d  = out_data_q;
        if (acc && !bypass) valid_d[in_ch][in_rob] = 1'b1;
        if (load_en) begin
            out_valid_d = |req;
            if (|req) begin
                out_ch_d   = gnt_ch;
                out_rob_d  = head_q[gnt_ch];
                out_data_d = bypass ? bus.sc_xbar_data : mem_q[gnt_ch][head_q[gnt_ch]];
                valid_d[gnt_ch][head_q[gnt_ch]] = 1'b0;
                head_d[gnt_ch] = head_q[gnt_ch] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < CH_NUM; c++) begin
                valid_q[c] <= '0;
                head_q[c]  <= '0;
            end
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_rob_q   <= '0;
            out_data_q  <= '0;
        end else begin
            valid_q     <= valid_d;
            head_q      <= head_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_rob_q   <= out_rob_d;
            out_data_q  <= out_data_d;
        end
    end

    // Data needs no reset: the valid bits gate every read.
    always_ff @(posedge clk_i) begin
        if (acc && !bypass) mem_q[in_ch][in_rob] <= bus.sc_xbar_data;
    end

    assign bus.xbar_rtn_valid      = out_valid_q;
    assign bus.xbar_rtn_channel_id = out_ch_q;
    assign bus.xbar_rtn_rob_num    = out_rob_q;
    assign bus.xbar_rtn_data       = out_data_q;
    assign bus.rob_empty           = rob_empty;
endmodule

// File: tb/tb_bank_rtn_rob.sv
// Scoreboard bench for bank_rtn_rob; expected beats queued in release order, popped on handshake.
module tb_bank_rtn_rob;
    localparam int unsigned CH_NUM    = 4;
    localparam int unsigned ROB_DEPTH = 8;
    localparam int unsigned DATA_W    = 128;
    localparam int unsigned CH_W      = 2;
    localparam int unsigned ROB_W     = 3;

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [ROB_W-1:0]  rob;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    beat_t expq[$];
    beat_t mon_e;
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    bank_rtn_rob_if #(.CH_NUM(CH_NUM), .ROB_DEPTH(ROB_DEPTH), .DATA_W(DATA_W)) bus ();

    bank_rtn_rob #(
        .CH_NUM(CH_NUM),
        .ROB_DEPTH(ROB_DEPTH),
        .DATA_W(DATA_W)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    function automatic logic [DATA_W-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic beat_t mk(input int ch, input int rob, input logic [DATA_W-1:0] d);
        beat_t b;
        b.ch   = CH_W'(ch);
        b.rob  = ROB_W'(rob);
        b.data = d;
        return b;
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.xbar_rtn_valid && bus.xbar_rtn_ready) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got ch=%0d rob=%0d, required no beat",
                         bus.xbar_rtn_channel_id, bus.xbar_rtn_rob_num);
            end else begin
                mon_e = expq.pop_front();
                if (bus.xbar_rtn_channel_id !== mon_e.ch || bus.xbar_rtn_rob_num !== mon_e.rob ||
                    bus.xbar_rtn_data !== mon_e.data) begin
                    errors++;
                    $display("FAIL out_beat: got ch=%0d rob=%0d data=%h, required ch=%0d rob=%0d data=%h",
                             bus.xbar_rtn_channel_id, bus.xbar_rtn_rob_num, bus.xbar_rtn_data,
                             mon_e.ch, mon_e.rob, mon_e.data);
                end
            end
        end
    end

    // Entered and left at posedge+1; leaves valid asserted on return.
    task automatic send(input int ch, input int rob, input logic [DATA_W-1:0] d);
        bus.sc_xbar_channel_id = CH_W'(ch);
        bus.sc_xbar_rob_num    = ROB_W'(rob);
        bus.sc_xbar_data       = d;
        bus.sc_xbar_valid      = 1'b1;
        for (int n = 0; n < 50; n++) begin
            #1;
            if (bus.sc_xbar_ready) begin
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: ch=%0d rob=%0d not accepted, required accept within 50 cycles",
                 ch, rob);
        bus.sc_xbar_valid = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        expq.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.sc_xbar_valid      = 1'b1;
        bus.sc_xbar_channel_id = 2'd2;
        bus.sc_xbar_rob_num    = 3'd5;
        bus.xbar_rtn_ready     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks += 6;
        if (bus.xbar_rtn_valid !== 1'b0) begin
            errors++; $display("FAIL rst_valid: got %b, required 0", bus.xbar_rtn_valid);
        end
        if (bus.xbar_rtn_channel_id !== 2'd0) begin
            errors++; $display("FAIL rst_ch: got %0d, required 0", bus.xbar_rtn_channel_id);
        end
        if (bus.xbar_rtn_rob_num !== 3'd0) begin
            errors++; $display("FAIL rst_rob: got %0d, required 0", bus.xbar_rtn_rob_num);
        end
        if (bus.xbar_rtn_data !== '0) begin
            errors++; $display("FAIL rst_data: got %h, required 0", bus.xbar_rtn_data);
        end
        if (bus.rob_empty !== 4'hF) begin
            errors++; $display("FAIL rst_empty: got %b, required 1111", bus.rob_empty);
        end
        if (bus.sc_xbar_ready !== 1'b0) begin
            errors++; $display("FAIL rst_ready: got %b, required 0", bus.sc_xbar_ready);
        end
        rst = 1'b0;
        bus.sc_xbar_valid  = 1'b0;
        bus.xbar_rtn_ready = 1'b0;
        #1;
        checks++;
        if (bus.sc_xbar_ready !== 1'b1) begin
            errors++; $display("FAIL post_rst_ready: got %b, required 1", bus.sc_xbar_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_idle_latency();
        logic [DATA_W-1:0] d;
        logic              exp_v;
        logic [3:0]        exp_e;
        reset_dut();
        bus.xbar_rtn_ready = 1'b1;
        d = rnd_data();
        expq.push_back(mk(0, 0, d));
        send(0, 0, d);
        bus.sc_xbar_valid = 1'b0;
`ifdef BANK_RTN_ROB_BYPASS_EN
        exp_v = 1'b1;
        exp_e = 4'hF;
`else
        exp_v = 1'b0;
        exp_e = 4'hE;
`endif
        checks += 2;
        if (bus.xbar_rtn_valid !== exp_v) begin
            errors++; $display("FAIL idle_lat_valid: got %b, required %b", bus.xbar_rtn_valid, exp_v);
        end
        if (bus.rob_empty !== exp_e) begin
            errors++; $display("FAIL idle_lat_empty: got %b, required %b", bus.rob_empty, exp_e);
        end
        for (int n = 0; n < 40 && expq.size() != 0; n++) begin @(posedge clk); #1; end
        checks++;
        if (expq.size() != 0) begin
            errors++; $display("FAIL idle_lat_drain: got %0d pending, required 0", expq.size());
        end
    endtask

    task automatic test_in_order();
        logic [DATA_W-1:0] d [8];
        logic [11:0]       seen, exp_seen;
        reset_dut();
        bus.xbar_rtn_ready = 1'b1;
        seen = '0;
        for (int i = 0; i < 8; i++) begin
            d[i] = rnd_data();
            expq.push_back(mk(0, i, d[i]));
        end
        for (int i = 0; i < 8; i++) begin
            bus.sc_xbar_channel_id = 2'd0;
            bus.sc_xbar_rob_num    = ROB_W'(i);
            bus.sc_xbar_data       = d[i];
            bus.sc_xbar_valid      = 1'b1;
            #1;
            checks++;
            if (bus.sc_xbar_ready !== 1'b1) begin
                errors++; $display("FAIL inorder_ready: rob %0d got %b, required 1", i, bus.sc_xbar_ready);
            end
            @(posedge clk);
            #1;
            seen[i] = bus.xbar_rtn_valid;
        end
        bus.sc_xbar_valid = 1'b0;
        for (int i = 8; i < 12; i++) begin
            @(posedge clk);
            #1;
            seen[i] = bus.xbar_rtn_valid;
        end
`ifdef BANK_RTN_ROB_BYPASS_EN
        exp_seen = 12'b0000_1111_1111;
`else
        exp_seen = 12'b0001_1111_1110;
`endif
        checks++;
        if (seen !== exp_seen) begin
            errors++; $display("FAIL inorder_timing: got %b, required %b", seen, exp_seen);
        end
        for (int n = 0; n < 40 && expq.size() != 0; n++) begin @(posedge clk); #1; end
        checks += 2;
        if (expq.size() != 0) begin
            errors++; $display("FAIL inorder_drain: got %0d pending, required 0", expq.size());
        end
        if (bus.rob_empty !== 4'hF) begin
            errors++; $display("FAIL inorder_empty: got %b, required 1111", bus.rob_empty);
        end
    endtask

    task automatic test_reverse();
        logic [DATA_W-1:0] d [4];
        logic [5:0]        seen;
        bus.xbar_rtn_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d[i] = rnd_data();
            expq.push_back(mk(1, i, d[i]));
        end
        for (int i = 3; i > 0; i--) begin
            send(1, i, d[i]);
            bus.sc_xbar_valid = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        checks += 2;
        if (bus.xbar_rtn_valid !== 1'b0) begin
            errors++; $display("FAIL reverse_early: got valid %b, required 0", bus.xbar_rtn_valid);
        end
        if (bus.rob_empty !== 4'b1101) begin
            errors++; $display("FAIL reverse_empty: got %b, required 1101", bus.rob_empty);
        end
        send(1, 0, d[0]);
        bus.sc_xbar_valid = 1'b0;
        seen[0] = bus.xbar_rtn_valid;
        for (int i = 1; i < 6; i++) begin
            @(posedge clk);
            #1;
            seen[i] = bus.xbar_rtn_valid;
        end
        checks++;
        if (seen !== 6'b011110) begin
            errors++; $display("FAIL reverse_timing: got %b, required 011110", seen);
        end
        for (int n = 0; n < 40 && expq.size() != 0; n++) begin @(posedge clk); #1; end
        checks++;
        if (expq.size() != 0) begin
            errors++; $display("FAIL reverse_drain: got %0d pending, required 0", expq.size());
        end
    endtask

    task automatic test_rr();
        logic [DATA_W-1:0] d [5];
        reset_dut();
        bus.xbar_rtn_ready = 1'b0;
        for (int i = 0; i < 5; i++) d[i] = rnd_data();
        expq.push_back(mk(0, 0, d[0]));
        expq.push_back(mk(1, 0, d[2]));
        expq.push_back(mk(2, 0, d[3]));
        expq.push_back(mk(3, 0, d[4]));
        expq.push_back(mk(0, 1, d[1]));
        send(0, 0, d[0]);
        send(0, 1, d[1]);
        send(1, 0, d[2]);
        send(2, 0, d[3]);
        send(3, 0, d[4]);
        bus.sc_xbar_valid = 1'b0;
        checks++;
        if (bus.xbar_rtn_valid !== 1'b1 || bus.xbar_rtn_channel_id !== 2'd0) begin
            errors++; $display("FAIL rr_first: got valid %b ch %0d, required valid 1 ch 0",
                               bus.xbar_rtn_valid, bus.xbar_rtn_channel_id);
        end
        bus.xbar_rtn_ready = 1'b1;
        for (int n = 0; n < 40 && expq.size() != 0; n++) begin @(posedge clk); #1; end
        checks++;
        if (expq.size() != 0) begin
            errors++; $display("FAIL rr_drain1: got %0d pending, required 0", expq.size());
        end
        // Last grant was ch0; make ch2 the latest winner, then contend ch0/ch1/ch3.
        bus.xbar_rtn_ready = 1'b0;
        for (int i = 0; i < 4; i++) d[i] = rnd_data();
        expq.push_back(mk(2, 1, d[0]));
        expq.push_back(mk(3, 1, d[2]));
        expq.push_back(mk(0, 2, d[3]));
        expq.push_back(mk(1, 1, d[1]));
        send(2, 1, d[0]);
        send(1, 1, d[1]);
        send(3, 1, d[2]);
        send(0, 2, d[3]);
        bus.sc_xbar_valid  = 1'b0;
        bus.xbar_rtn_ready = 1'b1;
        for (int n = 0; n < 40 && expq.size() != 0; n++) begin @(posedge clk); #1; end
        checks++;
        if (expq.size() != 0) begin
            errors++; $display("FAIL rr_drain2: got %0d pending, required 0", expq.size());
        end
    endtask

    task automatic test_full();
        logic [DATA_W-1:0] d1, d3, dx;
        logic [DATA_W-1:0] d2 [8];
        reset_dut();
        bus.xbar_rtn_ready = 1'b0;
        d1 = rnd_data();
        d3 = rnd_data();
        dx = rnd_data();
        for (int i = 0; i < 8; i++) d2[i] = rnd_data();
        expq.push_back(mk(1, 0, d1));
        expq.push_back(mk(2, 0, d2[0]));
        expq.push_back(mk(3, 0, d3));
        for (int i = 1; i < 8; i++) expq.push_back(mk(2, i, d2[i]));
        send(1, 0, d1);
        for (int i = 0; i < 8; i++) send(2, i, d2[i]);
        bus.sc_xbar_rob_num = 3'd0;
        bus.sc_xbar_data    = dx;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.sc_xbar_ready !== 1'b0) begin
                errors++; $display("FAIL full_stall: cycle %0d got ready %b, required 0",
                                   i, bus.sc_xbar_ready);
            end
            @(posedge clk);
            #1;
        end
        bus.sc_xbar_valid = 1'b0;
        send(3, 0, d3);
        bus.sc_xbar_valid = 1'b0;
        checks += 2;
        if (bus.rob_empty !== 4'b0011) begin
            errors++; $display("FAIL full_empty: got %b, required 0011", bus.rob_empty);
        end
        if (bus.xbar_rtn_valid !== 1'b1 || bus.xbar_rtn_channel_id !== 2'd1 ||
            bus.xbar_rtn_rob_num !== 3'd0 || bus.xbar_rtn_data !== d1) begin
            errors++; $display("FAIL full_hold: got v%b ch%0d rob%0d %h, required v1 ch1 rob0 %h",
                               bus.xbar_rtn_valid, bus.xbar_rtn_channel_id, bus.xbar_rtn_rob_num,
                               bus.xbar_rtn_data, d1);
        end
        bus.xbar_rtn_ready = 1'b1;
        for (int n = 0; n < 40 && expq.size() != 0; n++) begin @(posedge clk); #1; end
        @(posedge clk);
        #1;
        checks += 2;
        if (expq.size() != 0) begin
            errors++; $display("FAIL full_drain: got %0d pending, required 0", expq.size());
        end
        if (bus.rob_empty !== 4'hF) begin
            errors++; $display("FAIL full_empty_end: got %b, required 1111", bus.rob_empty);
        end
    endtask

    task automatic test_mid_reset();
        logic [DATA_W-1:0] d;
        bus.xbar_rtn_ready = 1'b0;
        // ch3 head sits at 1 here; these beats are discarded by the reset.
        for (int i = 1; i < 6; i++) send(3, i, rnd_data());
        bus.sc_xbar_valid = 1'b0;
        checks++;
        if (bus.xbar_rtn_valid !== 1'b1) begin
            errors++; $display("FAIL midrst_pre: got valid %b, required 1", bus.xbar_rtn_valid);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks += 2;
        if (bus.xbar_rtn_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_valid: got %b, required 0", bus.xbar_rtn_valid);
        end
        if (bus.rob_empty !== 4'hF) begin
            errors++; $display("FAIL midrst_empty: got %b, required 1111", bus.rob_empty);
        end
        bus.sc_xbar_channel_id = 2'd3;
        bus.sc_xbar_rob_num    = 3'd3;
        #1;
        checks++;
        if (bus.sc_xbar_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_ready: got %b, required 1", bus.sc_xbar_ready);
        end
        @(posedge clk);
        #1;
        bus.xbar_rtn_ready = 1'b1;
        d = rnd_data();
        expq.push_back(mk(3, 0, d));
        send(3, 0, d);
        bus.sc_xbar_valid = 1'b0;
        for (int n = 0; n < 40 && expq.size() != 0; n++) begin @(posedge clk); #1; end
        checks++;
        if (expq.size() != 0) begin
            errors++; $display("FAIL midrst_drain: got %0d pending, required 0", expq.size());
        end
    endtask

    initial begin
        bus.sc_xbar_valid      = 1'b0;
        bus.sc_xbar_channel_id = '0;
        bus.sc_xbar_rob_num    = '0;
        bus.sc_xbar_data       = '0;
        bus.xbar_rtn_ready     = 1'b0;
        test_reset();
        test_idle_latency();
        test_in_order();
        test_reverse();
        test_rr();
        test_full();
        test_mid_reset();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 time units, required earlier finish");
        $fatal(1, "watchdog");
    end
endmodule
